// File: rtl/ysyx_25020037_axi_arbiter_if.sv
// Full AXI4 bus bundle (AR, R, AW, W, B) shared by the IFU, LSU and memory-side
// ports of the arbiter. The master modport drives requests; the slave modport answers them.
interface ysyx_25020037_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [ID_W-1:0]     bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid,
           awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, rid,
           awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4 memory port between the IFU (read-only)
// and the LSU (read/write); the grant is held until the final response beat.
module ysyx_25020037_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_25020037_axi_arbiter_if.slave   ifu,
  ysyx_25020037_axi_arbiter_if.slave   lsu,
  ysyx_25020037_axi_arbiter_if.master  m
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    IFU_RD = 4'b0010,
    LSU_RD = 4'b0100,
    LSU_WR = 4'b1000
  } state_t;

  state_t r_state;
  logic   r_last_grant;   // 0: IFU served last, 1: LSU served last

  logic w_ifu_req;
  logic w_lsu_req;

  assign w_ifu_req = ifu.arvalid;
  assign w_lsu_req = lsu.awvalid | lsu.arvalid;

  // The IFU never writes; its write-side inputs are sunk here.
  logic [ADDR_W-1:0]   w_ifu_awaddr_unused;
  logic [ID_W-1:0]     w_ifu_awid_unused;
  logic [DATA_W-1:0]   w_ifu_wdata_unused;
  logic [DATA_W/8-1:0] w_ifu_wstrb_unused;
  logic                w_unused;

  assign w_ifu_awaddr_unused = ifu.awaddr;
  assign w_ifu_awid_unused   = ifu.awid;
  assign w_ifu_wdata_unused  = ifu.wdata;
  assign w_ifu_wstrb_unused  = ifu.wstrb;
  assign w_unused = ^{ifu.awvalid, ifu.awlen, ifu.awsize, ifu.awburst,
                      ifu.wvalid, ifu.wlast, ifu.bready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ifu_req && (!w_lsu_req || r_last_grant)) begin
            r_state      <= IFU_RD;
            r_last_grant <= 1'b0;
          end else if (w_lsu_req) begin
            r_state      <= lsu.awvalid ? LSU_WR : LSU_RD;
            r_last_grant <= 1'b1;
          end
        end
        IFU_RD, LSU_RD: begin
          if (m.rvalid && m.rready && m.rlast) r_state <= IDLE;
        end
        LSU_WR: begin
          if (m.bvalid && m.bready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything not belonging to the granted transaction is held at zero.
  always_comb begin
    ifu.arready = '0; ifu.rvalid = '0; ifu.rdata = '0; ifu.rresp = '0;
    ifu.rlast   = '0; ifu.rid    = '0; ifu.awready = '0; ifu.wready = '0;
    ifu.bvalid  = '0; ifu.bresp  = '0; ifu.bid = '0;

    lsu.arready = '0; lsu.rvalid = '0; lsu.rdata = '0; lsu.rresp = '0;
    lsu.rlast   = '0; lsu.rid    = '0; lsu.awready = '0; lsu.wready = '0;
    lsu.bvalid  = '0; lsu.bresp  = '0; lsu.bid = '0;

    m.arvalid = '0; m.araddr = '0; m.arid = '0; m.arlen = '0; m.arsize = '0;
    m.arburst = '0; m.rready = '0;
    m.awvalid = '0; m.awaddr = '0; m.awid = '0; m.awlen = '0; m.awsize = '0;
    m.awburst = '0;
    m.wvalid  = '0; m.wdata  = '0; m.wstrb = '0; m.wlast = '0; m.bready = '0;

    unique case (r_state)
      IFU_RD: begin
        m.arvalid   = ifu.arvalid;
        m.araddr    = ifu.araddr;
        m.arid      = ifu.arid;
        m.arlen     = ifu.arlen;
        m.arsize    = ifu.arsize;
        m.arburst   = ifu.arburst;
        ifu.arready = m.arready;
        ifu.rvalid  = m.rvalid;
        ifu.rdata   = m.rdata;
        ifu.rresp   = m.rresp;
        ifu.rlast   = m.rlast;
        ifu.rid     = m.rid;
        m.rready    = ifu.rready;
      end
      LSU_RD: begin
        m.arvalid   = lsu.arvalid;
        m.araddr    = lsu.araddr;
        m.arid      = lsu.arid;
        m.arlen     = lsu.arlen;
        m.arsize    = lsu.arsize;
        m.arburst   = lsu.arburst;
        lsu.arready = m.arready;
        lsu.rvalid  = m.rvalid;
        lsu.rdata   = m.rdata;
        lsu.rresp   = m.rresp;
        lsu.rlast   = m.rlast;
        lsu.rid     = m.rid;
        m.rready    = lsu.rready;
      end
      LSU_WR: begin
        m.awvalid   = lsu.awvalid;
        m.awaddr    = lsu.awaddr;
        m.awid      = lsu.awid;
        m.awlen     = lsu.awlen;
        m.awsize    = lsu.awsize;
        m.awburst   = lsu.awburst;
        lsu.awready = m.awready;
        m.wvalid    = lsu.wvalid;
        m.wdata     = lsu.wdata;
        m.wstrb     = lsu.wstrb;
        m.wlast     = lsu.wlast;
        lsu.wready  = m.wready;
        lsu.bvalid  = m.bvalid;
        lsu.bresp   = m.bresp;
        lsu.bid     = m.bid;
        m.bready    = lsu.bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Bench acting as IFU master, LSU master and memory slave; a request-set model
// predicts the order in which pending transactions reach the memory port.
module tb_ysyx_25020037_axi_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_25020037_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) ifu_bus ();
  ysyx_25020037_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) lsu_bus ();
  ysyx_25020037_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_bus ();

  ysyx_25020037_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifu   (ifu_bus),
    .lsu   (lsu_bus),
    .m     (m_bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Transaction kinds: 0 = IFU read, 1 = LSU write, 2 = LSU read
  logic [31:0] t_addr [3];
  logic [3:0]  t_id   [3];
  logic [7:0]  t_len  [3];
  logic [1:0]  t_resp [3];
  logic [3:0]  t_strb;
  logic        model_last;   // 1 when the LSU was the most recent master served

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Fairness rule: a lone requester wins; on conflict the master not served last wins;
  // the LSU presents its write before its read.
  function automatic int pick(input logic [2:0] p, input logic last_was_lsu);
    bit ifu_wants, lsu_wants, ifu_wins;
    ifu_wants = p[0];
    lsu_wants = p[1] | p[2];
    if (ifu_wants && lsu_wants) ifu_wins = last_was_lsu;
    else                        ifu_wins = ifu_wants;
    if (ifu_wins) return 0;
    return p[1] ? 1 : 2;
  endfunction

  task automatic clear_drivers();
    ifu_bus.arvalid = 0; ifu_bus.araddr = 0; ifu_bus.arid = 0; ifu_bus.arlen = 0;
    ifu_bus.arsize = 0; ifu_bus.arburst = 0; ifu_bus.rready = 0;
    ifu_bus.awvalid = 0; ifu_bus.awaddr = 0; ifu_bus.awid = 0; ifu_bus.awlen = 0;
    ifu_bus.awsize = 0; ifu_bus.awburst = 0; ifu_bus.wvalid = 0; ifu_bus.wdata = 0;
    ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 0;
    lsu_bus.arvalid = 0; lsu_bus.araddr = 0; lsu_bus.arid = 0; lsu_bus.arlen = 0;
    lsu_bus.arsize = 0; lsu_bus.arburst = 0; lsu_bus.rready = 0;
    lsu_bus.awvalid = 0; lsu_bus.awaddr = 0; lsu_bus.awid = 0; lsu_bus.awlen = 0;
    lsu_bus.awsize = 0; lsu_bus.awburst = 0; lsu_bus.wvalid = 0; lsu_bus.wdata = 0;
    lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 0;
    m_bus.arready = 0; m_bus.rvalid = 0; m_bus.rdata = 0; m_bus.rresp = 0;
    m_bus.rlast = 0; m_bus.rid = 0; m_bus.awready = 0; m_bus.wready = 0;
    m_bus.bvalid = 0; m_bus.bresp = 0; m_bus.bid = 0;
  endtask

  task automatic bubble_check();
    #1;
    check("bubble_arvalid", m_bus.arvalid, 0);
    check("bubble_awvalid", m_bus.awvalid, 0);
  endtask

  task automatic serve_read(input int k);
    logic [31:0] d;
    @(posedge clk); #1;
    check("ar_fwd_valid", m_bus.arvalid, 1);
    check("ar_fwd_addr", m_bus.araddr, t_addr[k]);
    check("ar_fwd_id", m_bus.arid, t_id[k]);
    check("ar_fwd_len", m_bus.arlen, t_len[k]);
    check("ar_fwd_burst", m_bus.arburst, 2'b01);
    check("aw_idle_in_rd", m_bus.awvalid, 0);
    m_bus.arready = 1;
    #1;
    check("ar_ready_granted", (k == 0) ? ifu_bus.arready : lsu_bus.arready, 1);
    check("ar_ready_other", (k == 0) ? lsu_bus.arready : ifu_bus.arready, 0);
    @(posedge clk); #1;
    m_bus.arready = 0;
    if (k == 0) begin ifu_bus.arvalid = 0; ifu_bus.rready = 1; end
    else        begin lsu_bus.arvalid = 0; lsu_bus.rready = 1; end
    for (int unsigned b = 0; b <= t_len[k]; b++) begin
      repeat ($urandom_range(0, 1)) begin
        m_bus.rvalid = 0;
        @(posedge clk); #1;
      end
      d = $urandom;
      m_bus.rvalid = 1; m_bus.rdata = d; m_bus.rresp = t_resp[k];
      m_bus.rlast = (b == t_len[k]); m_bus.rid = t_id[k];
      #1;
      if (k == 0) begin
        check("ifu_rvalid", ifu_bus.rvalid, 1);
        check("ifu_rdata", ifu_bus.rdata, d);
        check("ifu_rresp", ifu_bus.rresp, t_resp[k]);
        check("ifu_rlast", ifu_bus.rlast, (b == t_len[k]));
        check("ifu_rid", ifu_bus.rid, t_id[k]);
        check("lsu_rvalid_blocked", lsu_bus.rvalid, 0);
        check("lsu_awready_blocked", lsu_bus.awready, 0);
      end else begin
        check("lsu_rvalid", lsu_bus.rvalid, 1);
        check("lsu_rdata", lsu_bus.rdata, d);
        check("lsu_rresp", lsu_bus.rresp, t_resp[k]);
        check("lsu_rlast", lsu_bus.rlast, (b == t_len[k]));
        check("ifu_rvalid_blocked", ifu_bus.rvalid, 0);
      end
      check("m_rready", m_bus.rready, 1);
      @(posedge clk); #1;
      m_bus.rvalid = 0; m_bus.rlast = 0;
    end
    ifu_bus.rready = 0; lsu_bus.rready = 0;
    bubble_check();
  endtask

  task automatic serve_write();
    logic [31:0] d;
    @(posedge clk); #1;
    check("aw_fwd_valid", m_bus.awvalid, 1);
    check("aw_fwd_addr", m_bus.awaddr, t_addr[1]);
    check("aw_fwd_id", m_bus.awid, t_id[1]);
    check("aw_fwd_len", m_bus.awlen, t_len[1]);
    check("ar_idle_in_wr", m_bus.arvalid, 0);
    m_bus.awready = 1;
    #1;
    check("lsu_awready", lsu_bus.awready, 1);
    check("lsu_arready_in_wr", lsu_bus.arready, 0);
    @(posedge clk); #1;
    m_bus.awready = 0; lsu_bus.awvalid = 0;
    for (int unsigned b = 0; b <= t_len[1]; b++) begin
      d = $urandom;
      lsu_bus.wvalid = 1; lsu_bus.wdata = d; lsu_bus.wstrb = t_strb;
      lsu_bus.wlast = (b == t_len[1]); m_bus.wready = 1;
      #1;
      check("w_fwd_valid", m_bus.wvalid, 1);
      check("w_fwd_data", m_bus.wdata, d);
      check("w_fwd_strb", m_bus.wstrb, t_strb);
      check("w_fwd_last", m_bus.wlast, (b == t_len[1]));
      check("lsu_wready", lsu_bus.wready, 1);
      check("ifu_arready_in_wr", ifu_bus.arready, 0);
      @(posedge clk); #1;
    end
    lsu_bus.wvalid = 0; lsu_bus.wlast = 0; m_bus.wready = 0;
    m_bus.bvalid = 1; m_bus.bresp = t_resp[1]; m_bus.bid = t_id[1]; lsu_bus.bready = 1;
    #1;
    check("lsu_bvalid", lsu_bus.bvalid, 1);
    check("lsu_bresp", lsu_bus.bresp, t_resp[1]);
    check("lsu_bid", lsu_bus.bid, t_id[1]);
    check("m_bready", m_bus.bready, 1);
    @(posedge clk); #1;
    m_bus.bvalid = 0; lsu_bus.bready = 0;
    bubble_check();
  endtask

  task automatic run(input logic [2:0] req);
    logic [2:0] pend;
    int k;
    if (req[0]) begin
      ifu_bus.arvalid = 1; ifu_bus.araddr = t_addr[0]; ifu_bus.arid = t_id[0];
      ifu_bus.arlen = t_len[0]; ifu_bus.arsize = 3'd2; ifu_bus.arburst = 2'b01;
    end
    if (req[1]) begin
      lsu_bus.awvalid = 1; lsu_bus.awaddr = t_addr[1]; lsu_bus.awid = t_id[1];
      lsu_bus.awlen = t_len[1]; lsu_bus.awsize = 3'd2; lsu_bus.awburst = 2'b01;
    end
    if (req[2]) begin
      lsu_bus.arvalid = 1; lsu_bus.araddr = t_addr[2]; lsu_bus.arid = t_id[2];
      lsu_bus.arlen = t_len[2]; lsu_bus.arsize = 3'd2; lsu_bus.arburst = 2'b01;
    end
    #1;
    check("idle_arvalid", m_bus.arvalid, 0);
    check("idle_awvalid", m_bus.awvalid, 0);
    pend = req;
    while (pend != 0) begin
      k = pick(pend, model_last);
      model_last = (k != 0);
      pend[k] = 1'b0;
      if (k == 1) serve_write();
      else        serve_read(k);
    end
  endtask

  task automatic set_txn(input int k, input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] resp);
    t_addr[k] = a; t_id[k] = id; t_len[k] = len; t_resp[k] = resp;
  endtask

  task automatic reset_mid_burst();
    set_txn(0, 32'hA000_0000, 4'h3, 8'd3, 2'b00);
    ifu_bus.arvalid = 1; ifu_bus.araddr = t_addr[0]; ifu_bus.arid = t_id[0];
    ifu_bus.arlen = t_len[0]; ifu_bus.arsize = 3'd2; ifu_bus.arburst = 2'b01;
    @(posedge clk); #1;
    m_bus.arready = 1;
    @(posedge clk); #1;
    m_bus.arready = 0; ifu_bus.arvalid = 0; ifu_bus.rready = 1;
    m_bus.rvalid = 1; m_bus.rdata = 32'h1111_0000; m_bus.rid = t_id[0];
    @(posedge clk); #1;
    m_bus.rdata = 32'h2222_0001;
    #1;
    check("rst_pre_rvalid", ifu_bus.rvalid, 1);
    #1;
    rst_n = 0;
    #1;
    check("rst_async_rvalid", ifu_bus.rvalid, 0);
    check("rst_async_rdata", ifu_bus.rdata, 0);
    check("rst_async_rready", m_bus.rready, 0);
    clear_drivers();
    @(posedge clk); #1;
    rst_n = 1;
    model_last = 1'b1;
  endtask

  initial begin
    clear_drivers();
    t_strb = 4'hF;
    model_last = 1'b1;
    rst_n = 0;
    ifu_bus.arvalid = 1; ifu_bus.rready = 1; m_bus.rvalid = 1; m_bus.rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("reset_arvalid", m_bus.arvalid, 0);
    check("reset_rvalid", ifu_bus.rvalid, 0);
    check("reset_rdata", ifu_bus.rdata, 0);
    check("reset_rready", m_bus.rready, 0);
    check("reset_arready", ifu_bus.arready, 0);
    clear_drivers();
    rst_n = 1;
    @(posedge clk); #1;

    set_txn(0, 32'h3000_0000, 4'h1, 8'd0, 2'b00);
    run(3'b001);

    set_txn(0, 32'h3000_0100, 4'h2, 8'd1, 2'b00);
    set_txn(2, 32'h8000_0040, 4'h5, 8'd0, 2'b00);
    run(3'b101);
    run(3'b101);

    set_txn(0, 32'hA000_0000, 4'h3, 8'd3, 2'b00);
    set_txn(1, 32'h8000_1000, 4'h6, 8'd0, 2'b00);
    run(3'b011);

    set_txn(1, 32'h8000_2000, 4'h7, 8'd0, 2'b00);
    set_txn(2, 32'h8000_2004, 4'h8, 8'd0, 2'b00);
    run(3'b110);

    set_txn(0, 32'h3000_0200, 4'h9, 8'd0, 2'b10);
    run(3'b001);

    reset_mid_burst();
    set_txn(0, 32'h3000_0300, 4'hA, 8'd0, 2'b00);
    set_txn(2, 32'h8000_3000, 4'hB, 8'd0, 2'b00);
    run(3'b101);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++)
        set_txn(k, $urandom, 4'($urandom), 8'($urandom_range(0, 3)), 2'($urandom));
      t_strb = 4'($urandom);
      run(3'($urandom_range(1, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
